victim_tag_ctrl: RTL
====================

# victim_tag_ctrl

Command sequencer that drives the victim cache `tag_store` from the controller side. It accepts probe and insert requests from the L1 miss/evict path and turns each into a sequence of single-cycle `tag_store` commands: lookup, read, write, valid_clear and dirty_set. It keeps a shadow valid vector to pick replacement ways and issues writeback requests when a dirty line is displaced. Each request ends with a one-cycle response pulse.

## Interface
- TAG_WIDTH, 4: tag width, matches `tag_store`.
- NUM_WAYS, 4: ways, power of two, ≥2; WAY_W = $clog2(NUM_WAYS).

- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_op  in  1  0 = PROBE, 1 = INSERT.
- req_tag  in  TAG_WIDTH  request tag.
- req_dirty  in  1  INSERT: line is dirty.
- resp_valid  out  1  one-cycle completion pulse, no backpressure.
- resp_hit  out  1  lookup hit.
- resp_way  out  WAY_W  hit way (PROBE) or written way (INSERT); 0 on PROBE miss.
- resp_dirty  out  1  PROBE: dirty bit of the hit line. INSERT: a writeback was issued.
- wb_valid / wb_ready  out / in  1 / 1  writeback handshake.
- wb_tag  out  TAG_WIDTH  tag of the evicted dirty line.
- wb_way  out  WAY_W  way of the evicted dirty line.
- ts_lookup_en, ts_read_en, ts_write_en, ts_valid_clear, ts_dirty_set, ts_dirty_clear  out  1 each  `tag_store` commands.
- ts_tag_in  out  TAG_WIDTH  tag for lookup/write.
- ts_way_index  out  WAY_W  way for read/write/clear/dirty.
- ts_hit, ts_hit_way_index  in  1 / WAY_W  lookup result, valid the cycle after ts_lookup_en.
- ts_valid_read, ts_dirty_read, ts_tag_read  in  1 / 1 / TAG_WIDTH  read result, valid the cycle after ts_read_en.

## Operation
- Request capture: on req_valid && req_ready, register req_op, req_tag and req_dirty, then leave IDLE.
- `tag_store` commands: at most one ts_* command is high per cycle.
- `tag_store` write semantics: a write sets valid = 1 and dirty = 0.
- ts_dirty_clear is never asserted by this block; it is tied 0.
- FSM states: IDLE, LOOKUP, LK_CHK, READ, RD_CHK, WB, WRITE, DSET, CLEAR, RESP.
- LOOKUP: drive ts_lookup_en with ts_tag_in = req_tag.
- LK_CHK, PROBE hit: latch way = ts_hit_way_index, go to READ.
- LK_CHK, PROBE miss: go to RESP.
- READ → RD_CHK: capture ts_dirty_read and ts_tag_read.
- PROBE after RD_CHK: go to CLEAR (ts_valid_clear on the hit way; shadow bit cleared) → RESP with resp_dirty = captured dirty.
- LK_CHK, INSERT hit: way = hit way, go to WRITE. No writeback; the entry's dirty bit becomes req_dirty.
- LK_CHK, INSERT miss, free way exists: way = lowest-index way with shadow valid = 0, go to WRITE.
- LK_CHK, INSERT miss, all ways valid: way = rr_ptr, go to READ.
- INSERT after RD_CHK: if the victim is dirty, go to WB; otherwise go to WRITE.
- WB: wb_valid held high with wb_tag/wb_way stable until wb_ready is sampled high, then go to WRITE.
- Replacement pointer: rr_ptr advances by one, wrapping mod NUM_WAYS, only when a valid way is replaced.
- WRITE: ts_write_en on the chosen way; shadow bit set. Then go to DSET if req_dirty, else RESP.
- DSET: ts_dirty_set on the same way, then RESP.
- RESP: resp_valid high for one cycle, then IDLE.

## Timing
- Reset values: every output is 0 except req_ready = 1. State = IDLE, shadow valid = 0, rr_ptr = 0, captured fields = 0.
- Reset mid-operation aborts immediately. No partial command is held; the system resets `tag_store` concurrently.
- Latency, with the accept edge at cycle 0; resp_valid is high in the cycle listed:
  - PROBE miss: cycle 3.
  - PROBE hit: cycle 6.
  - INSERT to free way or hit: cycle 4 clean, cycle 5 dirty.
  - INSERT replacing a clean victim: cycle 6 clean, cycle 7 dirty.
  - INSERT replacing a dirty victim: WB begins in cycle 5; the tail after the wb handshake adds 2 cycles (clean) or 3 cycles (dirty).
- req_valid is ignored outside IDLE. A new request can be accepted in the cycle after RESP.
- resp_* fields are 0 whenever resp_valid = 0.
- When wb_ready is already high on the first WB cycle, WB lasts exactly one cycle.

## Test plan
- Reset, then INSERT tags A, B, C clean → resp_way 0, 1, 2 in turn; resp_hit = 0; resp_dirty = 0; each resp_valid lands 4 cycles after accept.
- PROBE B → resp_hit = 1, resp_way = 1, resp_dirty = 0 at cycle 6; ts_valid_clear on way 1. A second PROBE B → resp_hit = 0 at cycle 3.
- INSERT D dirty → fills way 1, the lowest free way; ts_dirty_set follows ts_write_en. Then PROBE D → resp_dirty = 1.
- Fill all 4 ways with way 0 dirty, then INSERT E → READ of way 0, wb_valid with wb_tag = way 0's tag. Hold wb_ready = 0 for 3 cycles: wb fields stay stable. Then the write to way 0 completes, resp_dirty = 1, and rr_ptr = 1.
- INSERT an existing tag C with req_dirty = 1 → resp_hit = 1, way 2, no wb_valid. Then PROBE C → resp_dirty = 1.
- Assert rst in the WB state → all outputs 0 asynchronously, req_ready = 1 after release. The next INSERT targets way 0 because the shadow vector was cleared.

Source files
------------

// File: rtl/victim_tag_ctrl.sv
// -----------------------------------------------------------------------------
// victim_tag_ctrl
//
// Controller-side command sequencer for the victim cache tag_store. Each
// PROBE or INSERT request from the L1 miss/evict path is turned into a short
// series of single-cycle tag_store commands (lookup, read, write, valid_clear,
// dirty_set). A shadow valid vector selects replacement ways. A round-robin
// pointer picks the victim when every way is valid, and displacing a dirty
// line raises a writeback handshake. Every request finishes with a one-cycle
// response pulse.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   req_*               request channel (req_ready high only while idle)
//   resp_*              one-cycle completion pulse carrying hit/way/dirty
//   wb_*                writeback handshake for an evicted dirty line
//   ts_* (out)          tag_store command strobes, tag and way index
//   ts_* (in)           tag_store lookup/read results, valid one cycle after
//                       the matching command
// -----------------------------------------------------------------------------
module victim_tag_ctrl #(
    parameter  int TAG_WIDTH = 4,
    parameter  int NUM_WAYS  = 4,
    localparam int WAY_W     = $clog2(NUM_WAYS)
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_op,
    input  logic [TAG_WIDTH-1:0] req_tag,
    input  logic                 req_dirty,

    output logic                 resp_valid,
    output logic                 resp_hit,
    output logic [WAY_W-1:0]     resp_way,
    output logic                 resp_dirty,

    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic [TAG_WIDTH-1:0] wb_tag,
    output logic [WAY_W-1:0]     wb_way,

    output logic                 ts_lookup_en,
    output logic                 ts_read_en,
    output logic                 ts_write_en,
    output logic                 ts_valid_clear,
    output logic                 ts_dirty_set,
    output logic                 ts_dirty_clear,
    output logic [TAG_WIDTH-1:0] ts_tag_in,
    output logic [WAY_W-1:0]     ts_way_index,

    input  logic                 ts_hit,
    input  logic [WAY_W-1:0]     ts_hit_way_index,
    input  logic                 ts_valid_read,
    input  logic                 ts_dirty_read,
    input  logic [TAG_WIDTH-1:0] ts_tag_read
);

    typedef enum logic [3:0] {
        IDLE,
        LOOKUP,
        LK_CHK,
        READ,
        RD_CHK,
        WB,
        WRITE,
        DSET,
        CLEAR,
        RESP
    } state_t;

    localparam logic OP_PROBE = 1'b0;

    state_t                state;
    logic                  op_q;
    logic [TAG_WIDTH-1:0]  tag_q;
    logic                  dirty_q;
    logic                  hit_q;
    logic [WAY_W-1:0]      way_q;
    // Dirty bit of the line read back: for PROBE it is reported directly,
    // for INSERT a dirty victim is exactly the case that issued a writeback,
    // so one register serves resp_dirty for both operations.
    logic                  victim_dirty_q;
    logic [NUM_WAYS-1:0]   shadow_valid;
    logic [WAY_W-1:0]      rr_ptr;

    logic                  free_found;
    logic [WAY_W-1:0]      free_way;
    logic [WAY_W-1:0]      insert_way;

    // This block never clears dirty bits; a tag_store write already does.
    assign ts_dirty_clear = 1'b0;

    // Lowest-index free way from the shadow valid vector.
    // NOTE: every always_comb output gets a default before any conditional
    // assignment, otherwise a latch is inferred for the untaken paths.
    always_comb begin
        free_found = 1'b0;
        free_way   = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (!shadow_valid[i]) begin
                free_found = 1'b1;
                free_way   = WAY_W'(i);
            end
        end
    end

    // INSERT way choice: hit way first, then a free way, then the RR victim.
    always_comb begin
        insert_way = rr_ptr;
        if (ts_hit) begin
            insert_way = ts_hit_way_index;
        end else if (free_found) begin
            insert_way = free_way;
        end
    end

    // Single registered FSM. Outputs are loaded on the edge that enters the
    // state they belong to, so every strobe is a clean flop output.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // branch below reads the pre-edge values of the registers it tests.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the shadow valid vector and rr_ptr are reset along with the
            // FSM because replacement decisions read them directly; tag_store
            // is cleared concurrently so both views start empty together.
            state          <= IDLE;
            op_q           <= 1'b0;
            tag_q          <= '0;
            dirty_q        <= 1'b0;
            hit_q          <= 1'b0;
            way_q          <= '0;
            victim_dirty_q <= 1'b0;
            shadow_valid   <= '0;
            rr_ptr         <= '0;
            req_ready      <= 1'b1;
            resp_valid     <= 1'b0;
            resp_hit       <= 1'b0;
            resp_way       <= '0;
            resp_dirty     <= 1'b0;
            wb_valid       <= 1'b0;
            wb_tag         <= '0;
            wb_way         <= '0;
            ts_lookup_en   <= 1'b0;
            ts_read_en     <= 1'b0;
            ts_write_en    <= 1'b0;
            ts_valid_clear <= 1'b0;
            ts_dirty_set   <= 1'b0;
            ts_tag_in      <= '0;
            ts_way_index   <= '0;
        end else begin
            // Single-cycle strobes and response fields fall back to 0.
            ts_lookup_en   <= 1'b0;
            ts_read_en     <= 1'b0;
            ts_write_en    <= 1'b0;
            ts_valid_clear <= 1'b0;
            ts_dirty_set   <= 1'b0;
            ts_tag_in      <= '0;
            ts_way_index   <= '0;
            resp_valid     <= 1'b0;
            resp_hit       <= 1'b0;
            resp_way       <= '0;
            resp_dirty     <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        op_q           <= req_op;
                        tag_q          <= req_tag;
                        dirty_q        <= req_dirty;
                        hit_q          <= 1'b0;
                        way_q          <= '0;
                        victim_dirty_q <= 1'b0;
                        req_ready      <= 1'b0;
                        ts_lookup_en   <= 1'b1;
                        ts_tag_in      <= req_tag;
                        state          <= LOOKUP;
                    end
                end

                LOOKUP: begin
                    state <= LK_CHK;
                end

                LK_CHK: begin
                    hit_q <= ts_hit;
                    if (op_q == OP_PROBE) begin
                        if (ts_hit) begin
                            way_q        <= ts_hit_way_index;
                            ts_read_en   <= 1'b1;
                            ts_way_index <= ts_hit_way_index;
                            state        <= READ;
                        end else begin
                            // Capture registers were cleared at accept, so a
                            // miss responds with hit/way/dirty all zero.
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end
                    end else begin
                        way_q <= insert_way;
                        if (ts_hit || free_found) begin
                            ts_write_en  <= 1'b1;
                            ts_tag_in    <= tag_q;
                            ts_way_index <= insert_way;
                            state        <= WRITE;
                        end else begin
                            // Every way valid: the RR victim is replaced, so
                            // the pointer moves on now.
                            rr_ptr       <= rr_ptr + WAY_W'(1);
                            ts_read_en   <= 1'b1;
                            ts_way_index <= insert_way;
                            state        <= READ;
                        end
                    end
                end

                READ: begin
                    state <= RD_CHK;
                end

                RD_CHK: begin
                    victim_dirty_q <= ts_valid_read && ts_dirty_read;
                    if (op_q == OP_PROBE) begin
                        shadow_valid[way_q] <= 1'b0;
                        ts_valid_clear      <= 1'b1;
                        ts_way_index        <= way_q;
                        state               <= CLEAR;
                    end else if (ts_valid_read && ts_dirty_read) begin
                        wb_valid <= 1'b1;
                        wb_tag   <= ts_tag_read;
                        wb_way   <= way_q;
                        state    <= WB;
                    end else begin
                        ts_write_en  <= 1'b1;
                        ts_tag_in    <= tag_q;
                        ts_way_index <= way_q;
                        state        <= WRITE;
                    end
                end

                WB: begin
                    // wb_tag/wb_way hold their values until the handshake.
                    if (wb_ready) begin
                        wb_valid     <= 1'b0;
                        wb_tag       <= '0;
                        wb_way       <= '0;
                        ts_write_en  <= 1'b1;
                        ts_tag_in    <= tag_q;
                        ts_way_index <= way_q;
                        state        <= WRITE;
                    end
                end

                WRITE: begin
                    shadow_valid[way_q] <= 1'b1;
                    if (dirty_q) begin
                        ts_dirty_set <= 1'b1;
                        ts_way_index <= way_q;
                        state        <= DSET;
                    end else begin
                        resp_valid <= 1'b1;
                        resp_hit   <= hit_q;
                        resp_way   <= way_q;
                        resp_dirty <= victim_dirty_q;
                        state      <= RESP;
                    end
                end

                DSET, CLEAR: begin
                    resp_valid <= 1'b1;
                    resp_hit   <= hit_q;
                    resp_way   <= way_q;
                    resp_dirty <= victim_dirty_q;
                    state      <= RESP;
                end

                RESP: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end

                default: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
